// File: rtl/accum_sram_pkg.sv
// Shared types for the accumulating SRAM: operation modes, FSM states and
// the signed-overflow helper.
package accum_sram_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      READ       = 2'd0,
      WRITE      = 2'd1,
      ACCUM      = 2'd2,
      READ_CLEAR = 2'd3
   } op_mode_e;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Two's-complement add overflows when both operands share a sign the sum lacks.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/accum_sram_if.sv
// Operation request / result bundle of accum_sram.
interface accum_sram_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256
);
   import accum_sram_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic                    op_valid;
   logic                    op_ready;
   logic [MODE_W-1:0]       op_mode;
   logic [AW-1:0]           op_addr;
   logic signed [WIDTH-1:0] op_data;
   logic                    rd_valid;
   logic [AW-1:0]           rd_addr;
   logic signed [WIDTH-1:0] rd_data;
   logic                    rd_ovf;
   logic                    init_busy;

   modport master (
      output op_valid, op_mode, op_addr, op_data,
      input  op_ready, rd_valid, rd_addr, rd_data, rd_ovf, init_busy
   );

   modport slave (
      input  op_valid, op_mode, op_addr, op_data,
      output op_ready, rd_valid, rd_addr, rd_data, rd_ovf, init_busy
   );

endinterface

// File: rtl/accum_sram_sram_1r1w.sv
// Storage for accum_sram: one synchronous read port and one write port;
// a same-address read and write in one cycle returns the old word.
module sram_1r1w #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Read port register; no reset, the array is initialised by the owner's sweep.
   always_ff @(posedge clk) begin
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   // Write port.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/accum_sram.sv
// Two-stage read-modify-write SRAM with READ/WRITE/ACCUM/READ_CLEAR ops and an
// init sweep. Define ACCUM_SRAM_SATURATE_EN to clamp ACCUM on overflow instead of wrapping.
module accum_sram
   import accum_sram_pkg::*;
#(
   parameter int                      WIDTH       = 32,
   parameter int                      DEPTH       = 256,
   parameter logic signed [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   accum_sram_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
`ifdef ACCUM_SRAM_SATURATE_EN
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   state_e           state_q, state_d;
   logic [AW-1:0]    sweep_cnt_q, sweep_cnt_d;

   logic             b_valid_q, b_valid_d;
   op_mode_e         b_mode_q, b_mode_d;
   logic [AW-1:0]    b_addr_q, b_addr_d;
   logic [WIDTH-1:0] b_data_q, b_data_d;
   logic             fwd_valid_q, fwd_valid_d;
   logic [WIDTH-1:0] fwd_data_q, fwd_data_d;

   logic             rd_valid_q, rd_valid_d;
   logic [AW-1:0]    rd_addr_q, rd_addr_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_ovf_q, rd_ovf_d;

   logic             accept_s;
   logic [WIDTH-1:0] mem_rd_data_s;
   logic [WIDTH-1:0] old_s, sum_s, accum_s, new_s;
   logic             ovf_s, b_wen_s;
   logic             mem_we_s;
   logic [AW-1:0]    mem_wa_s;
   logic [WIDTH-1:0] mem_wd_s;

   assign bus.op_ready  = (state_q == ST_READY) && !clear;
   assign bus.init_busy = (state_q == ST_INIT);
   assign accept_s      = bus.op_valid && bus.op_ready;

   // Init sweep / ready FSM next state.
   always_comb begin
      state_d     = state_q;
      sweep_cnt_d = sweep_cnt_q;
      case (state_q)
         ST_INIT: begin
            if (clear) begin
               sweep_cnt_d = '0;
            end else if (sweep_cnt_q == AW'(DEPTH - 1)) begin
               state_d     = ST_READY;
               sweep_cnt_d = '0;
            end else begin
               sweep_cnt_d = sweep_cnt_q + 1'b1;
            end
         end
         ST_READY: begin
            if (clear) begin
               state_d     = ST_INIT;
               sweep_cnt_d = '0;
            end else begin
               state_d     = ST_READY;
            end
         end
         default: begin
            state_d     = ST_INIT;
            sweep_cnt_d = '0;
         end
      endcase
   end

   // Stage B: pick the pre-op word (forwarded if the previous op just wrote it) and compute.
   always_comb begin
      old_s = fwd_valid_q ? fwd_data_q : mem_rd_data_s;
      sum_s = old_s + b_data_q;
      ovf_s = add_ovf(old_s[WIDTH-1], b_data_q[WIDTH-1], sum_s[WIDTH-1]);
`ifdef ACCUM_SRAM_SATURATE_EN
      if (ovf_s) begin
         accum_s = old_s[WIDTH-1] ? SMIN : SMAX;
      end else begin
         accum_s = sum_s;
      end
`else
      accum_s = sum_s;
`endif
      case (b_mode_q)
         READ:       new_s = old_s;
         WRITE:      new_s = b_data_q;
         ACCUM:      new_s = accum_s;
         READ_CLEAR: new_s = RESET_VALUE;
         default:    new_s = old_s;
      endcase
      b_wen_s = b_valid_q && (b_mode_q != READ);
   end

   // Write port: the sweep owns it in INIT, stage B otherwise.
   always_comb begin
      if (state_q == ST_INIT) begin
         mem_we_s = 1'b1;
         mem_wa_s = sweep_cnt_q;
         mem_wd_s = RESET_VALUE;
      end else begin
         mem_we_s = b_wen_s;
         mem_wa_s = b_addr_q;
         mem_wd_s = new_s;
      end
   end

   // Pipeline next state: capture accepted op, forwarding flag and result.
   always_comb begin
      b_valid_d = accept_s;
      if (accept_s) begin
         b_mode_d = op_mode_e'(bus.op_mode);
         b_addr_d = bus.op_addr;
         b_data_d = bus.op_data;
      end else begin
         b_mode_d = b_mode_q;
         b_addr_d = b_addr_q;
         b_data_d = b_data_q;
      end
      fwd_valid_d = accept_s && b_valid_q && (bus.op_addr == b_addr_q);
      fwd_data_d  = new_s;
      rd_valid_d  = b_valid_q;
      if (b_valid_q) begin
         rd_addr_d = b_addr_q;
         rd_data_d = old_s;
         rd_ovf_d  = (b_mode_q == ACCUM) && ovf_s;
      end else begin
         rd_addr_d = rd_addr_q;
         rd_data_d = rd_data_q;
         rd_ovf_d  = rd_ovf_q;
      end
   end

   // State and pipeline registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_INIT;
         sweep_cnt_q <= '0;
         b_valid_q   <= 1'b0;
         b_mode_q    <= READ;
         b_addr_q    <= '0;
         b_data_q    <= '0;
         fwd_valid_q <= 1'b0;
         fwd_data_q  <= '0;
         rd_valid_q  <= 1'b0;
         rd_addr_q   <= '0;
         rd_data_q   <= '0;
         rd_ovf_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sweep_cnt_q <= sweep_cnt_d;
         b_valid_q   <= b_valid_d;
         b_mode_q    <= b_mode_d;
         b_addr_q    <= b_addr_d;
         b_data_q    <= b_data_d;
         fwd_valid_q <= fwd_valid_d;
         fwd_data_q  <= fwd_data_d;
         rd_valid_q  <= rd_valid_d;
         rd_addr_q   <= rd_addr_d;
         rd_data_q   <= rd_data_d;
         rd_ovf_q    <= rd_ovf_d;
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_addr  = rd_addr_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_ovf   = rd_ovf_q;

   sram_1r1w #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_sram (
      .clk       (clk),
      .rd_en_i   (accept_s),
      .rd_addr_i (bus.op_addr),
      .rd_data_o (mem_rd_data_s),
      .wr_en_i   (mem_we_s),
      .wr_addr_i (mem_wa_s),
      .wr_data_i (mem_wd_s)
   );

endmodule

// File: tb/tb_accum_sram.sv
// Bench for accum_sram: two instances (RESET_VALUE -5 and 0) share one stimulus
// and are checked every cycle against an atomic-op memory model.
`timescale 1ns/1ps
module tb_accum_sram;
   import accum_sram_pkg::*;

   localparam int W = 16;
   localparam int D = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clear = 1'b0;
   always #5 clk = ~clk;

   accum_sram_if #(.WIDTH(W), .DEPTH(D)) ifa ();
   accum_sram_if #(.WIDTH(W), .DEPTH(D)) ifb ();

   accum_sram #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(-16'sd5)) dut_a (
      .clk(clk), .reset(reset), .clear(clear), .bus(ifa));
   accum_sram #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(16'sd0)) dut_b (
      .clk(clk), .reset(reset), .clear(clear), .bus(ifb));

   typedef struct {
      bit v;
      int addr;
      int data;
      bit ovf;
   } res_t;

   int   tests = 0;
   int   fails = 0;
   int   rv [2] = '{-5, 0};
   int   mem [2][D];
   int   init_left = D;
   res_t s1 [2];
   res_t s2 [2];
   int   log_a [$];
   int   log_b [$];
   bit   ovf_b [$];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Operations are atomic in acceptance order; hazards do not exist at this level.
   function automatic void apply(input int d, input int m, input int a, input int x, output res_t r);
      int     old;
      longint s;
      old    = mem[d][a];
      r.v    = 1'b1;
      r.addr = a;
      r.data = old;
      r.ovf  = 1'b0;
      case (m)
         0: ;
         1: mem[d][a] = x;
         2: begin
            s     = longint'(old) + longint'(x);
            r.ovf = (s > 32767) || (s < -32768);
`ifdef ACCUM_SRAM_SATURATE_EN
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
`else
            if (s > 32767) s = s - 65536;
            else if (s < -32768) s = s + 65536;
`endif
            mem[d][a] = int'(s);
         end
         default: mem[d][a] = rv[d];
      endcase
   endfunction

   task automatic fill(input int d);
      for (int i = 0; i < D; i++) mem[d][i] = rv[d];
   endtask

   // Model advance on each rising edge.
   always @(posedge clk) begin : model
      bit acc;
      if (reset) begin
         init_left = D;
         for (int d = 0; d < 2; d++) begin
            s1[d].v = 1'b0;
            s2[d].v = 1'b0;
            fill(d);
         end
      end else begin
         acc = ifa.op_valid && (init_left == 0) && !clear;
         for (int d = 0; d < 2; d++) begin
            s2[d] = s1[d];
            if (acc) apply(d, int'(ifa.op_mode), int'(ifa.op_addr), int'(ifa.op_data), s1[d]);
            else s1[d].v = 1'b0;
         end
         if (clear) begin
            init_left = D;
            fill(0);
            fill(1);
         end else if (init_left > 0) begin
            init_left--;
         end
      end
   end

   task automatic cmp_dut(input int d, input logic rdy, input logic busy, input logic vld,
                          input logic [3:0] ra, input logic signed [15:0] rd, input logic ovf);
      bit ev;
      ev = !reset && s2[d].v;
      chk($sformatf("dut%0d op_ready", d), int'(rdy), int'(!reset && (init_left == 0) && !clear));
      chk($sformatf("dut%0d init_busy", d), int'(busy), int'(reset || (init_left != 0)));
      chk($sformatf("dut%0d rd_valid", d), int'(vld), int'(ev));
      if (ev) begin
         chk($sformatf("dut%0d rd_addr", d), int'(ra), s2[d].addr);
         chk($sformatf("dut%0d rd_data", d), int'(rd), s2[d].data);
         chk($sformatf("dut%0d rd_ovf", d), int'(ovf), int'(s2[d].ovf));
      end
   endtask

   // Per-cycle compare and result logging, away from the active edge.
   always @(negedge clk) begin : compare
      cmp_dut(0, ifa.op_ready, ifa.init_busy, ifa.rd_valid, ifa.rd_addr, ifa.rd_data, ifa.rd_ovf);
      cmp_dut(1, ifb.op_ready, ifb.init_busy, ifb.rd_valid, ifb.rd_addr, ifb.rd_data, ifb.rd_ovf);
      if (ifa.rd_valid) log_a.push_back(int'(ifa.rd_data));
      if (ifb.rd_valid) begin
         log_b.push_back(int'(ifb.rd_data));
         ovf_b.push_back(ifb.rd_ovf);
      end
   end

   task automatic drive(input bit v, input int m, input int a, input int x, input bit c);
      @(posedge clk);
      #2;
      ifa.op_valid = v;      ifb.op_valid = v;
      ifa.op_mode  = 2'(m);  ifb.op_mode  = 2'(m);
      ifa.op_addr  = 4'(a);  ifb.op_addr  = 4'(a);
      ifa.op_data  = 16'(x); ifb.op_data  = 16'(x);
      clear        = c;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 0, 0, 1'b0);
   endtask

   task automatic clr_logs();
      log_a.delete();
      log_b.delete();
      ovf_b.delete();
   endtask

   // Counts not-ready cycles from the current one, bounded.
   task automatic count_busy(input string nm);
      int n;
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         if (ifb.op_ready) break;
         n++;
      end
      chk(nm, n, D);
   endtask

   int tv [10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
   int tm [10] = '{1, 2, 2, 0, 3, 2, 1, 2, 0, 0};
   int ta [10] = '{4, 4, 4, 0, 4, 4, 6, 6, 4, 6};
   int td [10] = '{-32768, -1, -1, 0, 0, 3, -200, -32700, 0, 0};

   initial begin : stim
      ifa.op_valid = 1'b0; ifb.op_valid = 1'b0;
      ifa.op_mode  = 2'd0; ifb.op_mode  = 2'd0;
      ifa.op_addr  = 4'd0; ifb.op_addr  = 4'd0;
      ifa.op_data  = 16'sd0; ifb.op_data = 16'sd0;

      @(negedge clk);
      chk("reset rd_valid", int'(ifa.rd_valid), 0);
      chk("reset rd_data", int'(ifa.rd_data), 0);
      chk("reset rd_addr", int'(ifa.rd_addr), 0);
      chk("reset rd_ovf", int'(ifa.rd_ovf), 0);
      chk("reset init_busy", int'(ifa.init_busy), 1);
      chk("reset op_ready", int'(ifb.op_ready), 0);

      @(posedge clk);
      #2;
      reset = 1'b0;
      count_busy("sweep cycles after reset");

      clr_logs();
      drive(1'b1, READ, 3, 0, 1'b0);
      idle(3);
      chk("read init rv=-5", log_a[0], -5);
      chk("read init count", log_a.size(), 1);

      clr_logs();
      drive(1'b1, ACCUM, 5, 10, 1'b0);
      drive(1'b1, ACCUM, 5, 20, 1'b0);
      drive(1'b1, ACCUM, 5, 30, 1'b0);
      drive(1'b1, READ, 5, 0, 1'b0);
      idle(4);
      chk("accum chain r0", log_b[0], 0);
      chk("accum chain r1", log_b[1], 10);
      chk("accum chain r2", log_b[2], 30);
      chk("accum chain read", log_b[3], 60);
      chk("accum chain count", log_b.size(), 4);

      clr_logs();
      drive(1'b1, WRITE, 2, 32760, 1'b0);
      drive(1'b1, ACCUM, 2, 10, 1'b0);
      drive(1'b1, READ, 2, 0, 1'b0);
      idle(4);
      chk("ovf write ovf", int'(ovf_b[0]), 0);
      chk("ovf accum old", log_b[1], 32760);
      chk("ovf accum flag", int'(ovf_b[1]), 1);
`ifdef ACCUM_SRAM_SATURATE_EN
      chk("ovf read saturated", log_b[2], 32767);
`else
      chk("ovf read wrapped", log_b[2], -32766);
`endif
      chk("ovf read flag", int'(ovf_b[2]), 0);

      clr_logs();
      drive(1'b1, WRITE, 7, 100, 1'b0);
      drive(1'b1, READ_CLEAR, 7, 0, 1'b0);
      drive(1'b1, READ, 7, 0, 1'b0);
      idle(4);
      chk("rdclr a old", log_a[1], 100);
      chk("rdclr a after", log_a[2], -5);
      chk("rdclr b old", log_b[1], 100);
      chk("rdclr b after", log_b[2], 0);

      clr_logs();
      for (int i = 0; i < 10; i++) drive(tv[i] != 0, tm[i], ta[i], td[i], 1'b0);
      idle(4);
      chk("mixed neg ovf old", log_b[1], -32768);
      chk("mixed neg ovf flag", int'(ovf_b[1]), 1);

      drive(1'b1, WRITE, 9, 55, 1'b0);
      drive(1'b1, ACCUM, 4, 1, 1'b0);
      drive(1'b1, WRITE, 9, 777, 1'b1);
      @(negedge clk);
      chk("clear blocks op_ready", int'(ifb.op_ready), 0);
      drive(1'b0, 0, 0, 0, 1'b0);
      count_busy("sweep cycles after clear");
      clr_logs();
      for (int i = 0; i < D; i++) drive(1'b1, READ, i, 0, 1'b0);
      idle(4);
      chk("post-clear count", log_b.size(), D);
      for (int i = 0; i < D; i++) begin
         chk($sformatf("post-clear a[%0d]", i), log_a[i], -5);
         chk($sformatf("post-clear b[%0d]", i), log_b[i], 0);
      end

      drive(1'b1, ACCUM, 1, 7, 1'b0);
      drive(1'b1, ACCUM, 1, 7, 1'b0);
      drive(1'b1, ACCUM, 1, 7, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      ifa.op_valid = 1'b0; ifb.op_valid = 1'b0;
      clr_logs();
      @(negedge clk);
      chk("reset drops rd_valid", int'(ifb.rd_valid), 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      count_busy("sweep cycles after mid reset");
      idle(3);
      chk("no stale result", log_b.size(), 0);
      drive(1'b1, READ, 1, 0, 1'b0);
      idle(3);
      chk("word after reset a", log_a[0], -5);
      chk("word after reset b", log_b[0], 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached (tests %0d, failed %0d)", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
